// File: rtl/mul_unit_seq.sv
// rtl/mul_unit_seq.sv - sequential shift-add multiplier for sign-magnitude operands
module mul_unit_seq #(
  parameter int N     = 32,
  parameter int MAG_W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c,
  output logic         cout,
  output logic         zero,
  output logic         overflow,
  output logic         neg
);

  localparam int CNT_W = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [MAG_W-1:0]     mag_a, mag_b;
  logic                 sgn;
  logic [2*MAG_W-1:0]   acc;
  logic [2*MAG_W-1:0]   addend;
  logic [CNT_W-1:0]     cnt;
  logic                 accept, last, bit_set;
  logic [N-1:0]         c_nxt;

  // Operand bits above the sign are don't-care by definition.
  logic unused_hi;
  assign unused_hi = ^{a[N-1:MAG_W+1], b[N-1:MAG_W+1]};

  assign accept  = start && (state != RUN);
  assign last    = (cnt == CNT_W'(MAG_W));
  assign bit_set = |(mag_b & (MAG_W'(1) << cnt));
  assign addend  = {{MAG_W{1'b0}}, mag_a} << cnt;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    c_nxt            = '0;
    c_nxt[MAG_W:0]   = {sgn, acc[MAG_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
      sgn   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mag_a <= a[MAG_W-1:0];
      mag_b <= b[MAG_W-1:0];
      sgn   <= a[MAG_W] ^ b[MAG_W];
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN && !last) begin
      if (bit_set) acc <= acc + addend;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Results only move on DONE entry and otherwise hold, including through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c        <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      neg      <= 1'b0;
    end else if (state == RUN && last) begin
      c        <= c_nxt;
      cout     <= acc[MAG_W];
      zero     <= (acc == '0);
      overflow <= |acc[2*MAG_W-1:MAG_W];
      neg      <= sgn;
    end
  end

endmodule

// File: tb/tb_mul_unit_seq.sv
// tb/tb_mul_unit_seq.sv - directed self-checking bench for mul_unit_seq
module tb_mul_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a, b, c;
  logic        busy, done, cout, zero, overflow, neg;
  int          checks = 0, failures = 0;
  int          cyc = 0, t_acc = 0, lat = 0;

  mul_unit_seq #(.N(32), .MAG_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .cout(cout), .zero(zero),
    .overflow(overflow), .neg(neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] aa, input logic [31:0] bb);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = cyc - t_acc;
  endtask

  task automatic do_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] ec, input logic ecout, input logic ezero,
                       input logic eovf, input logic eneg);
    start_op(aa, bb);
    wait_done();
    check({tag, ".lat"}, lat, 16);
    check({tag, ".c"}, c, ec);
    check({tag, ".flags"}, {cout, zero, overflow, neg}, {ecout, ezero, eovf, eneg});
    @(posedge clk); #1;
    check({tag, ".pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out", {busy, done, cout, zero, overflow, neg}, 6'b0);
    check("reset.c", c, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("basic",  32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0, 0, 0, 0);
    check("hold.c", c, 32'h0000_000F);
    do_op("neg",    32'h0000_8004, 32'h0000_0006, 32'h0000_8018, 0, 0, 0, 1);
    do_op("ovf",    32'h0000_0100, 32'h0000_0100, 32'h0000_0000, 0, 0, 1, 0);
    do_op("cout",   32'h0000_0080, 32'h0000_0100, 32'h0000_0000, 1, 0, 1, 0);
    do_op("zero",   32'h0000_0000, 32'h0000_7FFF, 32'h0000_0000, 0, 1, 0, 0);
    do_op("upper",  32'hFFFF_0002, 32'h0000_0003, 32'h0000_0006, 0, 0, 0, 0);
    do_op("negzero",32'h0000_8000, 32'h0000_0005, 32'h0000_8000, 0, 1, 0, 1);
    do_op("max",    32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_0001, 0, 0, 1, 0);

    // start held high through RUN must not restart the operation
    start_op(32'h0000_0003, 32'h0000_0005);
    a = 32'h0000_0009; b = 32'h0000_0009; start = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("busy.hold", {busy, done}, 2'b10);
    start = 1'b0;
    wait_done();
    check("busy.lat", lat, 16);
    check("busy.c", c, 32'h0000_000F);
    // back-to-back accept from the DONE cycle
    start_op(32'h0000_0002, 32'h0000_0007);
    check("b2b.state", {busy, done}, 2'b10);
    wait_done();
    check("b2b.lat", lat, 16);
    check("b2b.c", c, 32'h0000_000E);

    // reset during iteration 7 aborts with no done
    @(posedge clk); #1;
    start_op(32'h0000_8007, 32'h0000_0009);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.out", {busy, done, cout, zero, overflow, neg}, 6'b0);
    check("abort.c", c, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) check("abort.nodone", done, 1'b0);
    end
    check("abort.idle", {busy, done}, 2'b00);
    do_op("after",  32'h0000_8007, 32'h0000_8009, 32'h0000_003F, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
